// File: rtl/lc3_datapath_mem_if.sv
// Memory-side handshake between the LC-3 datapath and Mem2IO/SRAM.
// The datapath is the master: it raises mem_req and waits for mem_ack.
interface lc3_datapath_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/lc3_datapath_mem.sv
// LC-3 datapath: architectural registers, regfile, ALU, address adder, CC/BEN,
// gated bus with conflict flag, and a req/ack memory FSM with timeout.
module lc3_datapath_mem #(
    parameter int          LED_W       = 10,
    parameter bit          LED_HOLD    = 1'b0,
    parameter logic [15:0] PC_RESET    = 16'h0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_REG, LD_PC, LD_MDR, LD_MAR, LD_IR, LD_BEN, LD_CC, LD_LED,
    input  logic              GatePC, GateMDR, GateALU, GateMARMUX,
    input  logic [1:0]        ALUK, PCMUX, ADDR2MUX,
    input  logic              DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
    input  logic              mem_rd_start,
    input  logic              mem_wr_start,
    lc3_datapath_mem_if.master mem,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err,
    output logic              bus_err,
    output logic [15:0]       IR, PC, MAR, MDR,
    output logic              BEN,
    output logic [LED_W-1:0]  LED
);

    localparam int             CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} mstate_t;

    mstate_t     state, nstate;
    logic [CW-1:0] wait_cnt;
    logic        timeout_hit, rd_fill, start_ok;

    logic [15:0] regs [8];
    logic [15:0] bus, alu_out, alu_b, sr1_val, sr2_val, addr1, addr2, marmux;
    logic [2:0]  dr, sr1, cc;
    logic [3:0]  gates;
    logic        gate_conflict;

    // Bus: exactly one gate drives it; none or several read as zero.
    always_comb begin
        gates         = {GatePC, GateMDR, GateALU, GateMARMUX};
        gate_conflict = (gates & (gates - 4'd1)) != 4'd0;
        case (gates)
            4'b1000: bus = PC;
            4'b0100: bus = MDR;
            4'b0010: bus = alu_out;
            4'b0001: bus = marmux;
            default: bus = 16'h0000;
        endcase
    end

    always_comb begin
        dr      = DRMUX  ? 3'd7     : IR[11:9];
        sr1     = SR1MUX ? IR[8:6]  : IR[11:9];
        sr1_val = regs[sr1];
        sr2_val = regs[IR[2:0]];
        alu_b   = SR2MUX ? {{11{IR[4]}}, IR[4:0]} : sr2_val;
        case (ALUK)
            2'b00:   alu_out = sr1_val + alu_b;
            2'b01:   alu_out = sr1_val & alu_b;
            2'b10:   alu_out = ~sr1_val;
            default: alu_out = sr1_val;
        endcase
        addr1 = ADDR1MUX ? sr1_val : PC;
        case (ADDR2MUX)
            2'b00:   addr2 = 16'h0000;
            2'b01:   addr2 = {{10{IR[5]}},  IR[5:0]};
            2'b10:   addr2 = {{7{IR[8]}},   IR[8:0]};
            default: addr2 = {{5{IR[10]}},  IR[10:0]};
        endcase
        marmux = addr1 + addr2;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (LD_REG) begin
            regs[dr] <= bus;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            PC      <= PC_RESET;
            IR      <= 16'h0000;
            MAR     <= 16'h0000;
            cc      <= 3'b010;
            BEN     <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (LD_PC) begin
                case (PCMUX)
                    2'b00:   PC <= PC + 16'd1;
                    2'b01:   PC <= bus;
                    2'b10:   PC <= marmux;
                    default: PC <= PC;
                endcase
            end
            if (LD_IR)  IR  <= bus;
            if (LD_MAR) MAR <= bus;
            if (LD_CC)  cc  <= bus[15] ? 3'b100 : (bus == 16'h0000) ? 3'b010 : 3'b001;
            // BEN sees the CC value from before this edge, even if LD_CC fires too.
            if (LD_BEN) BEN <= |(IR[11:9] & cc);
            if (gate_conflict) bus_err <= 1'b1;
        end
    end

    // A read completion owns MDR over a bus load in the same cycle.
    assign rd_fill = (state == S_RD) && mem.mem_ack;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)       MDR <= 16'h0000;
        else if (rd_fill) MDR <= mem.mem_rdata;
        else if (LD_MDR)  MDR <= bus;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)      LED <= '0;
        else if (LD_LED) LED <= IR[LED_W-1:0];
        else if (!LED_HOLD) LED <= '0;
    end

    // Memory FSM: state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= nstate;
    end

    assign start_ok    = (state == S_IDLE) && (mem_rd_start || mem_wr_start);
    assign timeout_hit = (wait_cnt == CNT_LAST) && !mem.mem_ack;

    // Memory FSM: next state
    always_comb begin
        nstate = state;
        case (state)
            S_IDLE: begin
                if (mem_rd_start)      nstate = S_RD;
                else if (mem_wr_start) nstate = S_WR;
            end
            S_RD, S_WR: begin
                if (mem.mem_ack || timeout_hit) nstate = S_DONE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    // Memory FSM: outputs
    always_comb begin
        mem.mem_req = (state == S_RD) || (state == S_WR);
        mem.mem_we  = (state == S_WR);
        mem_done    = (state == S_DONE);
        mem_busy    = (state != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt      <= '0;
            mem.mem_addr  <= 16'h0000;
            mem.mem_wdata <= 16'h0000;
            mem_err       <= 1'b0;
        end else if (start_ok) begin
            wait_cnt      <= '0;
            mem.mem_addr  <= MAR;
            mem.mem_wdata <= MDR;
        end else if (mem.mem_req && !mem.mem_ack) begin
            if (timeout_hit) mem_err  <= 1'b1;
            else             wait_cnt <= wait_cnt + CW'(1);
        end
    end

endmodule
